// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package mem_ctrl_pkg;

  localparam int         WORD_W         = 32;
  localparam logic [1:0] IO_BASE_HI_DEF = 2'b11;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {IDLE, RD, WR, IOWAIT, DONE} st_t;

  // Request captured at acceptance; inputs are ignored until done.
  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [2:0]        nbytes;
    logic              ls;
  } req_t;

  // Size code 3 is illegal and falls back to a word access.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request ports (fetch, load/store) plus the byte-wide RAM/UART side.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic              if_req_in;
  logic [WORD_W-1:0] if_addr_in;
  logic              if_done_out;
  logic [WORD_W-1:0] if_data_out;

  logic              ls_req_in;
  logic              ls_we_in;
  logic [1:0]        ls_size_in;
  logic [WORD_W-1:0] ls_addr_in;
  logic [WORD_W-1:0] ls_wdata_in;
  logic              ls_done_out;
  logic [WORD_W-1:0] ls_rdata_out;

  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [WORD_W-1:0] mem_a;
  logic              mem_wr;
  logic              io_buffer_full;

  modport slave (
    input  if_req_in, if_addr_in, ls_req_in, ls_we_in, ls_size_in, ls_addr_in,
           ls_wdata_in, mem_din, io_buffer_full,
    output if_done_out, if_data_out, ls_done_out, ls_rdata_out,
           mem_dout, mem_a, mem_wr
  );

  modport master (
    output if_req_in, if_addr_in, ls_req_in, ls_we_in, ls_size_in, ls_addr_in,
           ls_wdata_in, mem_din, io_buffer_full,
    input  if_done_out, if_data_out, ls_done_out, ls_rdata_out,
           mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/mem_ctrl_arb.sv
// Two-way round-robin between fetch and load/store; ls wins the first tie.
module mem_ctrl_arb (
  input  logic clk_in,
  input  logic rst_in,
  input  logic if_req,
  input  logic ls_req,
  input  logic accept,
  output logic grant_ls
);

  logic last_ls;

  // On a tie the port that did not win last time gets the grant.
  assign grant_ls = ls_req && (!if_req || !last_ls);

  always_ff @(posedge clk_in) begin
    if (rst_in)      last_ls <= 1'b0;
    else if (accept) last_ls <= grant_ls;
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: one fetch/load/store at a time over an 8-bit
// RAM port, with UART back-pressure on I/O writes.
module mem_ctrl import mem_ctrl_pkg::*; #(
  parameter logic [1:0] IO_BASE_HI = IO_BASE_HI_DEF
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  mem_ctrl_if.slave  bus
);

  st_t               state, state_nx;
  req_t              cur, req_nx;
  logic              wr_nx;
  logic [2:0]        cnt;
  logic [WORD_W-1:0] rdata;
  logic              pend_vld;
  logic [1:0]        pend_idx;

  logic              grant_ls, accept;
  logic [WORD_W-1:0] byte_a;
  logic [7:0]        wbyte;
  logic              byte_io, last, rd_issue, wr_issue;

  logic [WORD_W-1:0] mem_a;
  logic [7:0]        mem_dout;
  logic              mem_wr, done;

  assign accept = (state == IDLE) && (bus.if_req_in || bus.ls_req_in);

  mem_ctrl_arb u_arb (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .if_req   (bus.if_req_in),
    .ls_req   (bus.ls_req_in),
    .accept   (accept && rdy_in),
    .grant_ls (grant_ls)
  );

  always_comb begin
    req_nx.ls     = grant_ls;
    req_nx.addr   = grant_ls ? bus.ls_addr_in : bus.if_addr_in;
    req_nx.wdata  = bus.ls_wdata_in;
    req_nx.nbytes = grant_ls ? size_bytes(bus.ls_size_in) : 3'd4;
    wr_nx         = grant_ls && bus.ls_we_in;
  end

  assign byte_a   = cur.addr + WORD_W'(cnt);
  assign byte_io  = (byte_a[17:16] == IO_BASE_HI);
  assign wbyte    = cur.wdata[{cnt[1:0], 3'b000} +: 8];
  assign last     = (cnt == cur.nbytes - 3'd1);
  assign rd_issue = (state == RD) && (cnt < cur.nbytes);
  assign wr_issue = (state == WR) && !(byte_io && bus.io_buffer_full);

  always_comb begin
    state_nx = state;
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:   if (accept) state_nx = wr_nx ? WR : RD;
      RD: begin
        if (rd_issue) mem_a = byte_a;
        else          state_nx = DONE;
      end
      WR: begin
        if (wr_issue) begin
          mem_a    = byte_a;
          mem_dout = wbyte;
          mem_wr   = 1'b1;
          // UART full flag lags a cycle, so every I/O byte is followed by a gap.
          if (byte_io)   state_nx = IOWAIT;
          else if (last) state_nx = DONE;
        end else begin
          state_nx = IOWAIT;
        end
      end
      IOWAIT: begin
        if (cnt == cur.nbytes)                     state_nx = DONE;
        else if (!(byte_io && bus.io_buffer_full)) state_nx = WR;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (!rdy_in) begin
      state_nx = state;
      mem_wr   = 1'b0;
      done     = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= IDLE;
      cur      <= '0;
      cnt      <= '0;
      rdata    <= '0;
      pend_vld <= 1'b0;
      pend_idx <= '0;
    end else begin
      // RAM answers the address of the previous cycle whatever rdy_in was,
      // so the capture follows issued addresses rather than the stall.
      pend_vld <= rdy_in && rd_issue;
      pend_idx <= cnt[1:0];
      if (pend_vld) rdata[{pend_idx, 3'b000} +: 8] <= bus.mem_din;
      if (rdy_in) begin
        state <= state_nx;
        if (accept) begin
          cur   <= req_nx;
          cnt   <= '0;
          rdata <= '0;
        end else if (rd_issue || wr_issue) begin
          cnt <= cnt + 3'd1;
        end else if (state == DONE) begin
          cnt <= '0;
        end
      end
    end
  end

  assign bus.mem_a        = mem_a;
  assign bus.mem_dout     = mem_dout;
  assign bus.mem_wr       = mem_wr;
  assign bus.if_done_out  = done && !cur.ls;
  assign bus.ls_done_out  = done &&  cur.ls;
  assign bus.if_data_out  = (done && !cur.ls) ? rdata : '0;
  assign bus.ls_rdata_out = (done &&  cur.ls) ? rdata : '0;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte RAM model (one-cycle read latency).
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b1;
  int   errors = 0;
  int   checks = 0;

  mem_ctrl_if bus();

  mem_ctrl #(.IO_BASE_HI(2'b11)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0] ram [logic [31:0]];

  function automatic logic [7:0] ram_init(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 8'h80;
      32'h0000_0100: return 8'h13;
      32'h0000_0101, 32'h0000_0102, 32'h0000_0103: return 8'h00;
      32'h0000_0200: return 8'h44;
      32'h0000_0201: return 8'h33;
      32'h0000_0202: return 8'h22;
      32'h0000_0203: return 8'h11;
      32'h0000_0204: return 8'h55;
      32'h0000_2000: return 8'h50;
      32'h0000_2001: return 8'h51;
      32'h0000_2002: return 8'h52;
      32'h0000_2003: return 8'h53;
      32'hFFFF_FFFE: return 8'hA1;
      32'hFFFF_FFFF: return 8'hB2;
      32'h0000_0000: return 8'hC3;
      32'h0000_0001: return 8'hD4;
      default:       return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return ram_init(a);
  endfunction

  always @(posedge clk_in) begin
    bus.mem_din <= ram_rd(bus.mem_a);
    if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
  end

  task automatic step;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs;
    bus.if_req_in      = 1'b0;
    bus.if_addr_in     = '0;
    bus.ls_req_in      = 1'b0;
    bus.ls_we_in       = 1'b0;
    bus.ls_size_in     = 2'd0;
    bus.ls_addr_in     = '0;
    bus.ls_wdata_in    = '0;
    bus.io_buffer_full = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_in = 1'b1;
    step(); step();
    checks++; if ({bus.if_done_out, bus.ls_done_out, bus.mem_wr} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {bus.if_done_out, bus.ls_done_out, bus.mem_wr}); end
    checks++; if (bus.mem_a !== 32'h0) begin
      errors++; $display("FAIL reset_mem_a: got %h want 0", bus.mem_a); end
    checks++; if (bus.mem_dout !== 8'h0) begin
      errors++; $display("FAIL reset_mem_dout: got %h want 0", bus.mem_dout); end
    checks++; if ({bus.if_data_out, bus.ls_rdata_out} !== 64'h0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {bus.if_data_out, bus.ls_rdata_out}); end
    bus.if_req_in  = 1'b1;
    bus.if_addr_in = 32'h100;
    step();
    checks++; if (bus.mem_a !== 32'h0) begin
      errors++; $display("FAIL reset_holds_idle: got mem_a %h want 0", bus.mem_a); end
    bus.if_req_in = 1'b0;
    rst_in = 1'b0;
    step();
  endtask

  task automatic test_fetch;
    logic [31:0] exp_a;
    bus.if_req_in  = 1'b1;
    bus.if_addr_in = 32'h100;
    step();
    for (int c = 1; c <= 6; c++) begin
      if (c == 1) bus.if_addr_in = 32'h0BAD_0000;
      exp_a = (c <= 4) ? 32'h100 + 32'(c - 1) : 32'h0;
      checks++; if ({bus.mem_wr, bus.mem_a} !== {1'b0, exp_a}) begin
        errors++; $display("FAIL fetch_addr c%0d: got wr=%b a=%h want wr=0 a=%h", c, bus.mem_wr, bus.mem_a, exp_a); end
      checks++; if (bus.if_done_out !== (c == 6)) begin
        errors++; $display("FAIL fetch_done c%0d: got %b want %b", c, bus.if_done_out, c == 6); end
      if (c == 6) begin
        checks++; if (bus.if_data_out !== 32'h0000_0013) begin
          errors++; $display("FAIL fetch_data: got %h want 00000013", bus.if_data_out); end
        bus.if_req_in = 1'b0;
      end
      if (c < 6) step();
    end
    step();
    checks++; if ({bus.if_done_out, bus.if_data_out} !== 33'h0) begin
      errors++; $display("FAIL fetch_after_done: got done=%b data=%h want 0", bus.if_done_out, bus.if_data_out); end
  endtask

  task automatic test_store_half;
    bus.ls_req_in   = 1'b1;
    bus.ls_we_in    = 1'b1;
    bus.ls_size_in  = 2'd1;
    bus.ls_addr_in  = 32'h2001;
    bus.ls_wdata_in = 32'hAABB_CCDD;
    step();
    checks++; if ({bus.mem_wr, bus.mem_a, bus.mem_dout} !== {1'b1, 32'h2001, 8'hDD}) begin
      errors++; $display("FAIL store_c1: got wr=%b a=%h d=%h want 1 2001 dd", bus.mem_wr, bus.mem_a, bus.mem_dout); end
    bus.ls_addr_in  = 32'h5555;
    bus.ls_wdata_in = 32'h0;
    step();
    checks++; if ({bus.mem_wr, bus.mem_a, bus.mem_dout} !== {1'b1, 32'h2002, 8'hCC}) begin
      errors++; $display("FAIL store_c2: got wr=%b a=%h d=%h want 1 2002 cc", bus.mem_wr, bus.mem_a, bus.mem_dout); end
    step();
    checks++; if ({bus.ls_done_out, bus.if_done_out, bus.mem_wr} !== 3'b100) begin
      errors++; $display("FAIL store_done: got %b want 100", {bus.ls_done_out, bus.if_done_out, bus.mem_wr}); end
    bus.ls_req_in = 1'b0;
    bus.ls_we_in  = 1'b0;
    step();
    checks++; if ({ram_rd(32'h2003), ram_rd(32'h2002), ram_rd(32'h2001), ram_rd(32'h2000)} !== 32'h53CC_DD50) begin
      errors++; $display("FAIL store_ram: got %h want 53ccdd50",
        {ram_rd(32'h2003), ram_rd(32'h2002), ram_rd(32'h2001), ram_rd(32'h2000)}); end
  endtask

  task automatic test_arb_byte_load;
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    bus.if_req_in  = 1'b1;
    bus.if_addr_in = 32'h200;
    bus.ls_req_in  = 1'b1;
    bus.ls_we_in   = 1'b0;
    bus.ls_size_in = 2'd0;
    bus.ls_addr_in = 32'h10;
    step();
    for (int c = 1; c <= 14; c++) begin
      if (c == 1 || c == 12) begin
        checks++; if (bus.mem_a !== 32'h10) begin
          errors++; $display("FAIL arb_ls_first c%0d: got mem_a %h want 10", c, bus.mem_a); end
      end
      if (c == 3 || c == 14) begin
        checks++; if ({bus.ls_done_out, bus.if_done_out} !== 2'b10) begin
          errors++; $display("FAIL arb_ls_done c%0d: got ls/if %b want 10", c, {bus.ls_done_out, bus.if_done_out}); end
        checks++; if (bus.ls_rdata_out !== 32'h0000_0080) begin
          errors++; $display("FAIL byte_load_data c%0d: got %h want 00000080", c, bus.ls_rdata_out); end
      end
      if (c == 5) begin
        checks++; if (bus.mem_a !== 32'h200) begin
          errors++; $display("FAIL arb_if_second: got mem_a %h want 200", bus.mem_a); end
      end
      if (c == 10) begin
        checks++; if ({bus.ls_done_out, bus.if_done_out} !== 2'b01) begin
          errors++; $display("FAIL arb_if_done: got ls/if %b want 01", {bus.ls_done_out, bus.if_done_out}); end
        checks++; if (bus.if_data_out !== 32'h1122_3344) begin
          errors++; $display("FAIL arb_if_data: got %h want 11223344", bus.if_data_out); end
        bus.if_req_in = 1'b0;
      end
      if (c == 14) bus.ls_req_in = 1'b0;
      step();
    end
  endtask

  task automatic test_io_stall;
    int stall_wr = 0;
    bus.io_buffer_full = 1'b1;
    bus.ls_req_in   = 1'b1;
    bus.ls_we_in    = 1'b1;
    bus.ls_size_in  = 2'd0;
    bus.ls_addr_in  = 32'h0003_0000;
    bus.ls_wdata_in = 32'hDEAD_BE41;
    step();
    for (int c = 1; c <= 7; c++) begin
      if (c == 4) bus.io_buffer_full = 1'b0;
      if (c <= 4 && (bus.mem_wr || bus.ls_done_out)) stall_wr++;
      if (c == 5) begin
        checks++; if ({bus.mem_wr, bus.mem_a, bus.mem_dout} !== {1'b1, 32'h0003_0000, 8'h41}) begin
          errors++; $display("FAIL io_write: got wr=%b a=%h d=%h want 1 00030000 41", bus.mem_wr, bus.mem_a, bus.mem_dout); end
      end
      if (c == 6) begin
        checks++; if ({bus.mem_wr, bus.ls_done_out} !== 2'b00) begin
          errors++; $display("FAIL io_gap: got wr/done %b want 00", {bus.mem_wr, bus.ls_done_out}); end
      end
      if (c == 7) begin
        checks++; if (bus.ls_done_out !== 1'b1) begin
          errors++; $display("FAIL io_done: got %b want 1", bus.ls_done_out); end
        bus.ls_req_in = 1'b0;
        bus.ls_we_in  = 1'b0;
      end
      step();
    end
    checks++; if (stall_wr !== 0) begin
      errors++; $display("FAIL io_stall_quiet: got %0d active cycles want 0", stall_wr); end
  endtask

  task automatic test_rdy_drop;
    int bad = 0;
    bus.if_req_in  = 1'b1;
    bus.if_addr_in = 32'h200;
    step();
    for (int c = 1; c <= 9; c++) begin
      if (c == 3) rdy_in = 1'b0;
      if (c == 5) rdy_in = 1'b1;
      if ((c == 3 || c == 4) && (bus.mem_wr || bus.if_done_out)) bad++;
      if (c == 7 || c == 9) begin
        checks++; if (bus.if_done_out !== 1'b0) begin
          errors++; $display("FAIL rdy_no_done c%0d: got %b want 0", c, bus.if_done_out); end
      end
      if (c == 8) begin
        checks++; if ({bus.if_done_out, bus.if_data_out} !== {1'b1, 32'h1122_3344}) begin
          errors++; $display("FAIL rdy_delayed_done: got done=%b data=%h want 1 11223344", bus.if_done_out, bus.if_data_out); end
        bus.if_req_in = 1'b0;
      end
      if (c < 9) step();
    end
    checks++; if (bad !== 0) begin
      errors++; $display("FAIL rdy_frozen: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_mid_reset;
    int dn = 0;
    bus.if_req_in  = 1'b1;
    bus.if_addr_in = 32'h200;
    step(); step();
    rst_in = 1'b1;
    rdy_in = 1'b0;
    bus.if_req_in = 1'b0;
    step();
    checks++; if ({bus.mem_wr, bus.mem_a, bus.if_done_out, bus.ls_done_out} !== 35'h0) begin
      errors++; $display("FAIL midrst_outputs: got wr=%b a=%h done=%b%b want 0", bus.mem_wr, bus.mem_a, bus.if_done_out, bus.ls_done_out); end
    rst_in = 1'b0;
    rdy_in = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (bus.if_done_out || bus.ls_done_out) dn++;
      step();
    end
    checks++; if (dn !== 0) begin
      errors++; $display("FAIL midrst_no_done: got %0d done cycles want 0", dn); end
    bus.ls_req_in  = 1'b1;
    bus.ls_we_in   = 1'b0;
    bus.ls_size_in = 2'd0;
    bus.ls_addr_in = 32'h10;
    step(); step(); step();
    checks++; if ({bus.ls_done_out, bus.ls_rdata_out} !== {1'b1, 32'h80}) begin
      errors++; $display("FAIL midrst_next: got done=%b data=%h want 1 00000080", bus.ls_done_out, bus.ls_rdata_out); end
    bus.ls_req_in = 1'b0;
    step();
  endtask

  task automatic test_wrap;
    bus.if_req_in  = 1'b1;
    bus.if_addr_in = 32'hFFFF_FFFE;
    step();
    for (int c = 1; c <= 6; c++) begin
      if (c == 3 || c == 4) begin
        checks++; if (bus.mem_a !== 32'(c - 3)) begin
          errors++; $display("FAIL wrap_addr c%0d: got %h want %h", c, bus.mem_a, 32'(c - 3)); end
      end
      if (c == 6) begin
        checks++; if ({bus.if_done_out, bus.if_data_out} !== {1'b1, 32'hD4C3_B2A1}) begin
          errors++; $display("FAIL wrap_data: got done=%b data=%h want 1 d4c3b2a1", bus.if_done_out, bus.if_data_out); end
        bus.if_req_in = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_size3_unaligned;
    bus.ls_req_in  = 1'b1;
    bus.ls_we_in   = 1'b0;
    bus.ls_size_in = 2'd3;
    bus.ls_addr_in = 32'h201;
    step();
    for (int c = 1; c <= 6; c++) begin
      if (c == 4) begin
        checks++; if (bus.mem_a !== 32'h204) begin
          errors++; $display("FAIL size3_addr: got %h want 204", bus.mem_a); end
      end
      if (c == 5) begin
        checks++; if (bus.ls_done_out !== 1'b0) begin
          errors++; $display("FAIL size3_early: got %b want 0", bus.ls_done_out); end
      end
      if (c == 6) begin
        checks++; if ({bus.ls_done_out, bus.ls_rdata_out} !== {1'b1, 32'h5511_2233}) begin
          errors++; $display("FAIL size3_data: got done=%b data=%h want 1 55112233", bus.ls_done_out, bus.ls_rdata_out); end
        bus.ls_req_in = 1'b0;
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_half();
    test_arb_byte_load();
    test_io_stall();
    test_rdy_drop();
    test_mid_reset();
    test_wrap();
    test_size3_unaligned();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter IO_BASE_HI, default 2'b11: value of addr[17:16] that marks an I/O access.
REQ-002 clk_in  input  1  system clock; single clock domain.
REQ-003 rst_in  input  1  reset, synchronous, active-high.
REQ-004 rdy_in  input  1  global ready; low freezes the block.
REQ-005 if_req_in  input  1  fetch request, held high until if_done_out.
REQ-006 if_addr_in  input  32  fetch byte address; always a 4-byte read.
REQ-007 if_done_out  output  1  one-cycle pulse: fetch complete.
REQ-008 if_data_out  output  32  fetched word, little-endian; valid only while if_done_out is high.
REQ-009 ls_req_in  input  1  load/store request, held high until ls_done_out.
REQ-010 ls_we_in  input  1  1 = store, 0 = load.
REQ-011 ls_size_in  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal and is treated as word.
REQ-012 ls_addr_in  input  32  load/store byte address; no alignment requirement.
REQ-013 ls_wdata_in  input  32  store data; low N bytes used.
REQ-014 ls_done_out  output  1  one-cycle pulse: load/store complete.
REQ-015 ls_rdata_out  output  32  load data, zero-extended, little-endian; valid only while ls_done_out is high.
REQ-016 mem_din  input  8  RAM read byte; returned one cycle after its address.
REQ-017 mem_dout  output  8  RAM write byte.
REQ-018 mem_a  output  32  RAM byte address.
REQ-019 mem_wr  output  1  1 = write, 0 = read.
REQ-020 io_buffer_full  input  1  UART TX buffer full.

Function
REQ-021 States: IDLE, RD, WR, IOWAIT, DONE.
REQ-022 Acceptance: a request is accepted only in IDLE with rdy_in=1; N (bytes) = 4 for fetch, or 1/2/4 from ls_size_in.
REQ-023 Arbitration, round-robin: ls wins a simultaneous request unless the previous grant was ls, in which case if wins.
REQ-024 Acceptance latches the address, size, write data and port; later input changes are ignored until done.
REQ-025 Read cycles: in the k-th cycle after acceptance (k = 1..N):
  - mem_a = addr + k - 1 and mem_wr = 0;
  - mem_din is sampled in cycle k+1 into byte k-1 of the result.
REQ-026 Read done: the done pulse is in cycle N+2; a word read from acceptance edge to done is 6 cycles.
REQ-027 Write cycles: in cycle k, mem_a = addr + k - 1, mem_dout = wdata byte k-1 and mem_wr = 1; the done pulse is in cycle N+1.
REQ-028 Address arithmetic is modulo 2^32; 0xFFFFFFFF + 1 wraps to 0.
REQ-029 I/O write byte: an I/O write byte (addr[17:16] == IO_BASE_HI) is issued only while io_buffer_full = 0.
  - Otherwise the block enters IOWAIT with mem_wr = 0 and retries each cycle.
  - After each issued I/O write byte, one idle gap cycle (mem_wr = 0) follows, because the flag lags by one cycle.
REQ-030 I/O reads use normal RD timing.
REQ-031 DONE state: DONE lasts exactly one cycle and asserts only the granted port's done signal; it then returns to IDLE.
  - No acceptance occurs in DONE, so a held request can never be re-accepted.
REQ-032 Idle outputs: outside active byte cycles, mem_wr = 0, mem_a = 0, mem_dout = 0.
REQ-033 Unused data outputs: if_data_out and ls_rdata_out are 0 when their port's done signal is low.
REQ-034 rdy_in = 0: all state, counters and registers hold; mem_wr is forced to 0; no done is pulsed; operation resumes exactly where it stopped.
REQ-035 Illegal case: a request port dropping req before its done signal is illegal; behaviour is unspecified but the block returns to IDLE.

Reset
REQ-036 Reset outcome: rst_in = 1 at a clock edge forces state IDLE, all outputs 0 and the last-grant flag to "if" (so ls wins the first tie).
REQ-037 Mid-operation reset: reset during an operation abandons it with no done pulse; rst_in overrides rdy_in.

Structure
REQ-038 A shared package mem_ctrl_pkg SHALL hold:
  - the state enum;
  - the size encodings;
  - the IO_BASE_HI default;
  - the word width constant.
REQ-039 The 2-way round-robin arbiter SHALL be the sub-module mem_ctrl_arb; the remainder is a single FSM with a 3-bit byte counter.

Verification
REQ-040 Word fetch: if_req at 0x100, RAM bytes 13 00 00 00 -> mem_a = 0x100..0x103 in cycles 1-4, if_done in cycle 6, if_data = 0x00000013.
REQ-041 Store half: ls store, size 1, addr 0x2001, wdata 0xAABBCCDD -> writes DD@0x2001 and CC@0x2002, ls_done in cycle 3, RAM unchanged elsewhere.
REQ-042 Arbitration and byte load: if and ls requests both high from reset -> ls served first, then if.
  - The ls load byte from 0x10 holding 0x80 returns ls_rdata = 0x00000080.
REQ-043 I/O stall: store byte 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> no mem_wr during the stall.
  - Then a single write of 0x41 followed by a gap cycle, and ls_done one cycle after the gap.
REQ-044 rdy_in drop: rdy_in low for 2 cycles mid word-read -> done is delayed by exactly 2 cycles with identical data.
  - Then rst_in pulsed mid-read -> no done, outputs 0, the next request is served normally.
